fifo_rr_arbiter: RTL and testbench

Round-robin read arbiter on the output side of the four-channel fifo8 bank. It pops one entry per cycle from any non-empty upstream FIFO and forwards it, tagged with its source channel, as a single push into the downstream FIFO. It throttles itself against the downstream occupancy count, so the downstream FIFO never overflows and no popped word is ever lost.

---
 rtl/fifo_rr_arbiter_pkg.sv | 15 +
 rtl/fifo_rr_arbiter_if.sv | 25 ++
 rtl/fifo_rr_arbiter_rr_pick.sv | 26 ++
 rtl/fifo_rr_arbiter.sv | 72 +++++++
 tb/tb_fifo_rr_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and helpers for the four-channel round-robin read arbiter.
package arb_pkg;
    localparam int NUM_CH   = 4;
    localparam int CH_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSE  = 2'd2
    } arb_state_e;

    function automatic logic [CH_IDX_W-1:0] next_idx(input logic [CH_IDX_W-1:0] i);
        return CH_IDX_W'((32'(i) + 1) % NUM_CH);
    endfunction
endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Upstream pop / downstream push bundle between the fifo8 bank and the arbiter.
interface fifo_rr_arbiter_if #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_CH     = 4,
    parameter int DOWN_CNT_W = 4
);
    logic                         enable;
    logic [NUM_CH-1:0]            in_empty;
    logic [NUM_CH*DATA_WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]            in_pop;
    logic [DOWN_CNT_W-1:0]        down_count;
    logic                         down_push;
    logic [DATA_WIDTH-1:0]        down_data;
    logic [1:0]                   down_src;
    logic                         busy;

    modport master (
        input  enable, in_empty, in_data, down_count,
        output in_pop, down_push, down_data, down_src, busy
    );
    modport slave (
        output enable, in_empty, in_data, down_count,
        input  in_pop, down_push, down_data, down_src, busy
    );
endinterface

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above last+1, wrapping.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_CH-1:0]   req,
    input  logic [CH_IDX_W-1:0] last,
    output logic [NUM_CH-1:0]   gnt,
    output logic [CH_IDX_W-1:0] gnt_idx
);
    always_comb begin
        logic [CH_IDX_W-1:0] idx;
        logic                found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = next_idx(last);
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
            idx = next_idx(idx);
        end
    end
endmodule

// File: rtl/fifo_rr_arbiter.sv
// Pops one word per cycle from the fifo8 bank and pushes it, source-tagged,
// into the downstream FIFO without ever overrunning it.
module fifo_rr_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int DOWN_DEPTH = 8,
    parameter int DOWN_CNT_W = 4
) (
    input logic               clk,
    input logic               rst,
    fifo_rr_arbiter_if.master bus
);
    localparam int SUM_W = DOWN_CNT_W + 1;

    arb_state_e          state_q, state_d;
    logic [CH_IDX_W-1:0] last_grant, sel_q, gnt_idx;
    logic [NUM_CH-1:0]   gnt;
    logic                push_q;
    logic [1:0]          vld_pipe;
    logic [SUM_W-1:0]    room_sum;
    logic                eligible;

    // Count the pending push too: it lands downstream one edge after any new pop.
    assign room_sum = SUM_W'(bus.down_count) + SUM_W'(push_q) + SUM_W'(1);
    assign eligible = (state_q == ACTIVE) && bus.enable &&
                      (room_sum <= SUM_W'(DOWN_DEPTH));

    rr_pick u_pick (
        .req     (~bus.in_empty & {NUM_CH{eligible}}),
        .last    (last_grant),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign vld_pipe = {push_q, |gnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_grant <= CH_IDX_W'(NUM_CH - 1);
            sel_q      <= '0;
            push_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            push_q  <= vld_pipe[0];
            if (vld_pipe[0]) begin
                last_grant <= gnt_idx;
                sel_q      <= gnt_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.enable) state_d = ACTIVE;
            ACTIVE:  if (!bus.enable) state_d = PAUSE;
            PAUSE: begin
                if (bus.enable)  state_d = ACTIVE;
                else if (!push_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_pop    = gnt;
    assign bus.down_push = vld_pipe[1];
    assign bus.down_data = bus.in_data[32'(sel_q) * DATA_WIDTH +: DATA_WIDTH];
    assign bus.down_src  = sel_q;
    assign bus.busy      = (state_q == ACTIVE) || push_q;
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Randomized + directed bench: queue-level model of the upstream bank, the
// round-robin rule and the downstream FIFO, with a scoreboard on the push side.
module tb_fifo_rr_arbiter;
    localparam int DW = 4, NCH = 4, DEPTH = 8, CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_rr_arbiter_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DOWN_CNT_W(CW)) bus ();

    fifo_rr_arbiter #(.DATA_WIDTH(DW), .DOWN_DEPTH(DEPTH), .DOWN_CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [1:0]    src;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mem [NCH][64];
    int            wp [NCH];
    int            rp [NCH];
    logic [DW-1:0] bufd [NCH];
    int            last_m, ds_cnt, cyc, exp_ch;
    int            checks, failures;
    bit            act_prev, pending, en_v, drain_v, push_s;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_word(input int ch, input logic [DW-1:0] v);
        mem[ch][wp[ch] % 64] = v;
        wp[ch]++;
    endtask

    function automatic int qsize(input int ch);
        return wp[ch] - rp[ch];
    endfunction

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            bus.in_empty[i]           = (qsize(i) == 0);
            bus.in_data[i*DW +: DW]   = bufd[i];
        end
        bus.down_count = CW'(ds_cnt);
        bus.enable     = en_v;
    endtask

    // The arbiter is ACTIVE exactly when enable was high at the previous edge.
    task automatic predict();
        exp_ch = -1;
        if (act_prev && en_v && !rst && (ds_cnt + int'(pending) + 1 <= DEPTH)) begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (last_m + k) % NCH;
                if (exp_ch < 0 && qsize(c) > 0) exp_ch = c;
            end
        end
    endtask

    task automatic cycle();
        logic [NCH-1:0] ep;
        bit             rd;
        exp_t           e;
        drive();
        predict();
        ep = '0;
        if (exp_ch >= 0) ep[exp_ch] = 1'b1;
        @(negedge clk);
        check("in_pop", int'(bus.in_pop), int'(ep));
        check("busy", int'(bus.busy), int'(act_prev || pending));
        check("down_occupancy_ok", int'(ds_cnt <= DEPTH), 1);
        push_s = bus.down_push;
        @(posedge clk);
        cyc++;
        rd = drain_v && (ds_cnt > 0);
        ds_cnt = ds_cnt + int'(push_s) - int'(rd);
        pending = (exp_ch >= 0);
        if (exp_ch >= 0) begin
            bufd[exp_ch] = mem[exp_ch][rp[exp_ch] % 64];
            rp[exp_ch]++;
            last_m = exp_ch;
            e.src  = 2'(exp_ch);
            e.data = bufd[exp_ch];
            e.cyc  = cyc;
            sb.push_back(e);
        end
        act_prev = en_v && !rst;
        #1;
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        act_prev = 1'b0;
        pending  = 1'b0;
        last_m   = 3;
        sb.delete();
        #1;
        check("rst_push_immediate", int'(bus.down_push), 0);
        check("rst_pop", int'(bus.in_pop), 0);
        repeat (n) cycle();
        check("rst_src", int'(bus.down_src), 0);
        check("rst_data", int'(bus.down_data), int'(bufd[0]));
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.down_push) begin
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    check("push_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("down_data", int'(bus.down_data), int'(e.data));
                    check("down_src", int'(bus.down_src), int'(e.src));
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                check("push_missing", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        checks = 0; failures = 0; cyc = 0; ds_cnt = 0; last_m = 3; exp_ch = -1;
        en_v = 1'b0; drain_v = 1'b1; pending = 1'b0; act_prev = 1'b0; push_s = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            wp[i] = 0; rp[i] = 0; bufd[i] = DW'(i + 5);
        end
        rst = 1'b0;
        drive();
        #1;
        do_reset(3);

        // Four single-word channels drain in order 0,1,2,3 from last_grant=3.
        for (int i = 0; i < NCH; i++) add_word(i, DW'(i + 1));
        en_v = 1'b1;
        repeat (8) cycle();

        // All empty while active, then one word arrives on channel 0.
        repeat (3) cycle();
        add_word(0, 4'hA);
        repeat (4) cycle();

        // Channel 2 alone with three words.
        add_word(2, 4'h3); add_word(2, 4'h6); add_word(2, 4'h9);
        repeat (6) cycle();

        // Downstream stalls: fill to capacity, then let it drain.
        drain_v = 1'b0;
        for (int i = 0; i < NCH; i++) for (int j = 0; j < 3; j++) add_word(i, DW'($urandom));
        repeat (16) cycle();
        drain_v = 1'b1;
        repeat (20) cycle();

        // enable dropped mid-stream, idle, then resume.
        for (int i = 0; i < NCH; i++) for (int j = 0; j < 2; j++) add_word(i, DW'($urandom));
        repeat (3) cycle();
        en_v = 1'b0;
        repeat (6) cycle();
        en_v = 1'b1;
        repeat (10) cycle();

        // Reset in the cycle right after a pop; channel 0 must win next.
        for (int i = 0; i < NCH; i++) for (int j = 0; j < 2; j++) add_word(i, DW'($urandom));
        for (int t = 0; t < 20 && !pending; t++) cycle();
        check("pop_before_reset", int'(pending), 1);
        do_reset(2);
        repeat (10) cycle();

        // Random traffic.
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 2) == 0 && qsize(i) < 50) add_word(i, DW'($urandom));
            en_v    = ($urandom_range(0, 15) != 0);
            drain_v = ($urandom_range(0, 3) != 0);
            cycle();
        end

        en_v = 1'b1; drain_v = 1'b1;
        for (int t = 0; t < 400 && (qsize(0) + qsize(1) + qsize(2) + qsize(3)) > 0; t++) cycle();
        repeat (4) cycle();
        en_v = 1'b0;
        repeat (12) cycle();
        check("upstream_drained", qsize(0) + qsize(1) + qsize(2) + qsize(3), 0);
        check("scoreboard_empty", sb.size(), 0);
        check("downstream_empty", ds_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
